// File: rtl/compare15_table_writer_if.sv
// Request/response bus of the comparator entry-table writer.
// The master issues write and read requests; the slave is the table writer.
interface compare15_table_writer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             wr_valid;
    logic             wr_ready;
    logic [1:0]       wr_mode;
    logic [3:0]       wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [3:0]       rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output wr_valid, wr_mode, wr_idx, wr_data, rd_en, rd_idx,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_mode, wr_idx, wr_data, rd_en, rd_idx,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/compare15_table_writer.sv
// Owns the 15-entry table searched by the match comparator.
// Supports indexed writes, append writes with an auto-increment pointer,
// a sequential 15-cycle clear-all sweep, and indexed read-back.
module compare15_table_writer #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] FILL  = 8'hFF
) (
    input  logic                    clk,
    input  logic                    rst,
    compare15_table_writer_if.slave bus,
    output logic [15*WIDTH-1:0]     entries,
    output logic [3:0]              count,
    output logic                    full,
    output logic                    err,
    output logic                    clr_done
);
    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [1:0] MODE_INDEXED = 2'b00;
    localparam logic [1:0] MODE_APPEND  = 2'b01;
    localparam logic [1:0] MODE_CLEAR   = 2'b10;

    state_t           state;
    logic [3:0]       p;
    logic [WIDTH-1:0] mem [15];

    // Table registers drive the comparator inputs directly.
    for (genvar k = 0; k < 15; k++) begin : g_entries
        assign entries[k*WIDTH +: WIDTH] = mem[k];
    end

    assign full = (count == 4'd15);

    // Request handling, clear sweep and read-back, all registered.
    // Reads sample mem with a non-blocking read, so a same-edge write
    // to the same index returns the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem          <= '{default: FILL};
            count        <= '0;
            p            <= '0;
            state        <= IDLE;
            bus.wr_ready <= 1'b1;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            err          <= 1'b0;
            clr_done     <= 1'b0;
        end else begin
            err          <= 1'b0;
            clr_done     <= 1'b0;
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_data <= (bus.rd_idx == 4'd15) ? '0 : mem[bus.rd_idx];
            end

            case (state)
                IDLE: begin
                    if (bus.wr_valid && bus.wr_ready) begin
                        case (bus.wr_mode)
                            MODE_INDEXED: begin
                                if (bus.wr_idx == 4'd15) begin
                                    err <= 1'b1;
                                end else begin
                                    mem[bus.wr_idx] <= bus.wr_data;
                                end
                            end
                            MODE_APPEND: begin
                                if (count == 4'd15) begin
                                    err <= 1'b1;
                                end else begin
                                    mem[count] <= bus.wr_data;
                                    count      <= count + 4'd1;
                                end
                            end
                            MODE_CLEAR: begin
                                state        <= CLEAR;
                                p            <= '0;
                                bus.wr_ready <= 1'b0;
                            end
                            default: begin
                                err <= 1'b1;
                            end
                        endcase
                    end
                end
                CLEAR: begin
                    mem[p] <= FILL;
                    if (p == 4'd14) begin
                        state        <= IDLE;
                        count        <= '0;
                        clr_done     <= 1'b1;
                        bus.wr_ready <= 1'b1;
                    end else begin
                        p <= p + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_compare15_table_writer.sv
// Directed testbench for the comparator entry-table writer.
module tb_compare15_table_writer;
    logic         clk;
    logic         rst;
    logic [119:0] entries;
    logic [3:0]   count;
    logic         full;
    logic         err;
    logic         clr_done;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  exp_mem [15];

    compare15_table_writer_if #(.WIDTH(8)) bus ();

    compare15_table_writer #(
        .WIDTH (8),
        .FILL  (8'hFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .entries  (entries),
        .count    (count),
        .full     (full),
        .err      (err),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [119:0] packed_model();
        logic [119:0] v;
        for (int k = 0; k < 15; k++) v[k*8 +: 8] = exp_mem[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_mode  = 2'b00;
        bus.wr_idx   = 4'd0;
        bus.wr_data  = 8'h00;
        bus.rd_en    = 1'b0;
        bus.rd_idx   = 4'd0;
    endtask

    initial begin
        idle_inputs();
        for (int k = 0; k < 15; k++) exp_mem[k] = 8'hFF;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_clr_done", clr_done, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_entries", entries, packed_model());
        @(negedge clk);
        rst = 1'b0;

        // Read back every index after reset, then the out-of-range index
        for (int k = 0; k < 16; k++) begin
            bus.rd_en  = 1'b1;
            bus.rd_idx = 4'(k);
            tick();
            check("rd_rst_valid", bus.rd_valid, 1);
            check("rd_rst_data", bus.rd_data, (k == 15) ? 0 : 8'hFF);
        end
        check("rd15_no_err", err, 0);
        idle_inputs();
        tick();
        check("rd_valid_drop", bus.rd_valid, 0);

        // Append 0x10..0x1E
        for (int k = 0; k < 15; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_mode  = 2'b01;
            bus.wr_data  = 8'h10 + 8'(k);
            exp_mem[k]   = 8'h10 + 8'(k);
            tick();
            check("app_count", count, k + 1);
            check("app_err", err, 0);
        end
        check("app_full", full, 1);
        check("app_entries", entries, packed_model());
        // 16th append rejected
        bus.wr_data = 8'h99;
        tick();
        check("app16_err", err, 1);
        check("app16_count", count, 15);
        check("app16_entries", entries, packed_model());
        idle_inputs();
        tick();
        check("app16_err_clear", err, 0);

        // Indexed write idx 5 with same-edge read of idx 5
        bus.wr_valid = 1'b1;
        bus.wr_mode  = 2'b00;
        bus.wr_idx   = 4'd5;
        bus.wr_data  = 8'hA5;
        bus.rd_en    = 1'b1;
        bus.rd_idx   = 4'd5;
        exp_mem[5]   = 8'hA5;
        tick();
        check("rbw_rd_data", bus.rd_data, 8'h15);
        check("idx_entries", entries, packed_model());
        check("idx_count", count, 15);
        check("idx_err", err, 0);
        bus.wr_valid = 1'b0;
        tick();
        check("rd_after_wr", bus.rd_data, 8'hA5);
        // Indexed write to idx 15 rejected
        bus.rd_en    = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_idx   = 4'd15;
        bus.wr_data  = 8'h3C;
        tick();
        check("idx15_err", err, 1);
        check("idx15_entries", entries, packed_model());
        idle_inputs();
        tick();
        check("idx15_err_clear", err, 0);

        // Reserved mode
        bus.wr_valid = 1'b1;
        bus.wr_mode  = 2'b11;
        bus.wr_data  = 8'h5A;
        tick();
        check("rsv_err", err, 1);
        check("rsv_count", count, 15);
        check("rsv_entries", entries, packed_model());
        check("rsv_wr_ready", bus.wr_ready, 1);
        idle_inputs();
        tick();

        // Clear-all from a full table, with a request held during the sweep
        bus.wr_valid = 1'b1;
        bus.wr_mode  = 2'b10;
        tick();
        check("clr_accept_ready", bus.wr_ready, 0);
        bus.wr_mode  = 2'b00;
        bus.wr_idx   = 4'd3;
        bus.wr_data  = 8'h55;
        for (int i = 1; i <= 15; i++) begin
            bus.rd_en  = (i == 5);
            bus.rd_idx = 4'd14;
            exp_mem[i-1] = 8'hFF;
            tick();
            check("clr_entries", entries, packed_model());
            check("clr_ready", bus.wr_ready, (i == 15) ? 1 : 0);
            check("clr_done", clr_done, (i == 15) ? 1 : 0);
            check("clr_count", count, (i == 15) ? 0 : 15);
            check("clr_err", err, 0);
            if (i == 5) check("clr_rd14", bus.rd_data, 8'h1E);
        end
        check("clr_e0", entries[7:0], 8'hFF);
        check("clr_e14", entries[119:112], 8'hFF);
        check("clr_full", full, 0);
        idle_inputs();
        tick();
        check("clr_done_pulse", clr_done, 0);
        check("clr_held_ignored", entries, packed_model());

        // Reset in the middle of a clear
        for (int k = 0; k < 3; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_mode  = 2'b01;
            bus.wr_data  = 8'h21 + 8'(k);
            exp_mem[k]   = 8'h21 + 8'(k);
            tick();
        end
        bus.wr_mode  = 2'b00;
        bus.wr_idx   = 4'd14;
        bus.wr_data  = 8'h77;
        exp_mem[14]  = 8'h77;
        tick();
        check("pre_clr_entries", entries, packed_model());
        check("pre_clr_count", count, 3);
        bus.wr_mode = 2'b10;
        tick();
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            exp_mem[i] = 8'hFF;
            tick();
        end
        check("mid_clr_entries", entries, packed_model());
        check("mid_clr_ready", bus.wr_ready, 0);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 15; k++) exp_mem[k] = 8'hFF;
        check("abort_entries", entries, packed_model());
        check("abort_ready", bus.wr_ready, 1);
        check("abort_count", count, 0);
        check("abort_clr_done", clr_done, 0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_abort_clr_done", clr_done, 0);
            check("post_abort_ready", bus.wr_ready, 1);
        end
        bus.wr_valid = 1'b1;
        bus.wr_mode  = 2'b00;
        bus.wr_idx   = 4'd0;
        bus.wr_data  = 8'h42;
        exp_mem[0]   = 8'h42;
        tick();
        check("post_abort_write", entries, packed_model());
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/compare15_table_writer.md
Name: compare15_table_writer

Overview:
- Owns the 15 x 8-bit entry table that feeds the 15 comparison inputs of the match comparator (entry k drives input k, 0..14).
- Provides the loading side of that interface: indexed writes, append writes with an auto-increment pointer, and a sequential clear-all.
- Provides indexed read-back, so an index returned by the match path can be turned back into its stored byte.
- Sits between the lab control logic/testbench and the comparator. It is the writer for the table the comparator searches.

Parameters:
WIDTH, 8, entry width in bits
FILL, 8'hFF, value loaded into every entry at reset and by clear-all

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
wr_valid  input  1  write request present
wr_ready  output  1  block can accept a request this cycle
wr_mode  input  2  00 indexed write, 01 append, 10 clear-all, 11 reserved
wr_idx  input  4  target index for indexed write (valid range 0..14)
wr_data  input  WIDTH  data for indexed or append write
rd_en  input  1  read request
rd_idx  input  4  read index
rd_data  output  WIDTH  registered read data
rd_valid  output  1  one-cycle pulse, rd_data is valid
entries  output  15*WIDTH  flattened table; entry k at bits [k*WIDTH +: WIDTH], driven directly from the registers
count  output  4  append pointer / number of appended entries, 0..15
full  output  1  count == 15
err  output  1  one-cycle pulse on a rejected request
clr_done  output  1  one-cycle pulse when clear-all completes

Behaviour:
- Reset (async, rst=1): all entries=FILL, count=0, state=IDLE, wr_ready=1, rd_data=0, rd_valid=0, err=0, clr_done=0, full=0. A reset during CLEAR aborts the sweep immediately.
- Handshake: a request is accepted on a rising edge where wr_valid && wr_ready. No request is taken while wr_ready=0.
- States:
  - IDLE: wr_ready=1.
  - CLEAR: wr_ready=0, internal pointer p.
- Indexed write (00):
  - wr_idx 0..14: entry[wr_idx] <= wr_data at the accepting edge.
  - wr_idx 15: no write; err=1 for the next cycle.
  - count is not changed.
- Append (01):
  - count<15: entry[count] <= wr_data and count <= count+1.
  - count==15: no write, count holds, err pulses.
- Clear-all (10):
  - Accepting edge: IDLE->CLEAR, p=0.
  - Each cycle in CLEAR: entry[p] <= FILL, p++.
  - On the edge that writes p=14: CLEAR->IDLE, count <= 0, clr_done=1 for one cycle.
  - wr_ready is 0 for exactly 15 cycles. Entries not yet swept keep their old values until swept.
- Reserved (11): no state change; err pulses.
- err and clr_done are registered. They are asserted one cycle after the cause and cleared the following cycle unless re-caused.
- full is combinational from count.
- Read:
  - rd_en sampled at the rising edge; rd_data/rd_valid are updated at that edge (latency 1).
  - rd_idx 15 returns rd_data=0 with rd_valid=1 and does not assert err.
  - Reads are allowed in any state, including CLEAR.
- Read/write collision (same index, same edge): the read returns the pre-write value (read-before-write).
- A request presented while wr_ready=0 is ignored: no err, no side effects.
- entries reflects a write in the cycle after the accepting edge. The comparator therefore sees new data one cycle after acceptance.

Test Plan:
- Reset, then read indices 0..14 -> every rd_data=8'hFF; count=0; full=0; wr_ready=1.
- Append 8'h10..8'h1E (15 requests), then one more append -> entries[k]=8'h10+k; count=15; full=1; 16th append gives err pulse with the table unchanged.
- Indexed write idx=5 data=8'hA5, plus read idx=5 on the same edge -> rd_data=old value 8'h15; the next read gives 8'hA5. Indexed write idx=15 -> err pulse, no entry changes.
- Clear-all from a full table -> wr_ready low for 15 cycles; entry[0] is FILL after cycle 1 while entry[14] keeps 8'h1E until the last sweep edge; clr_done pulses; count=0; a wr_valid held during the sweep is ignored.
- Assert rst mid-clear (after 7 sweep cycles) -> all entries=FILL immediately; state IDLE; wr_ready=1; no clr_done.
- wr_mode=11 -> err pulse, table and count unchanged.
